complex_mult_pipe: RTL and testbench

//  Pipelined, parametrised complex multiplier: p = a*b, with a = ar + j*ai and b = br + j*bi.

---
 rtl/cmul_pkg.sv | 25 ++
 rtl/cmul_mult_unit.sv | 46 ++++
 rtl/complex_mult_pipe.sv | 124 ++++++++++++
 tb/tb_complex_mult_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared constants, width helper and operand-pair type for the complex multiplier
//
// Contents:
//   CMUL_LAT    register stages from input transfer to out_valid
//   CMUL_MAXW   widest operand the pair type can carry
//   cmul_ow()   result width for a given operand width (2*W+2)
//   cmul_pair_t {re, im} operand pair, right-aligned in CMUL_MAXW-bit fields

package cmul_pkg;

    localparam int CMUL_LAT  = 3;
    localparam int CMUL_MAXW = 64;

    // Two extra bits over the raw product: one for the sum of two products,
    // one so that unsigned results still fit as two's complement.
    function automatic int cmul_ow(input int w);
        return 2 * w + 2;
    endfunction

    typedef struct packed {
        logic [CMUL_MAXW-1:0] re;
        logic [CMUL_MAXW-1:0] im;
    } cmul_pair_t;

endpackage

// File: rtl/cmul_mult_unit.sv
// rtl/cmul_mult_unit.sv - one registered WxW multiplier with clock enable and OW-extended output
//
// Ports:
//   clk  in   rising-edge clock
//   ce   in   load enable; the product register holds its value when low
//   a,b  in   W-bit operands, two's complement when SIGNED=1, unsigned otherwise
//   p    out  registered product, sign- or zero-extended to OW = 2*W+2 bits

module cmul_mult_unit
    import cmul_pkg::*;
#(
    parameter int      W      = 32,
    parameter bit      SIGNED = 1'b1,
    localparam int     OW     = cmul_ow(W)
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [OW-1:0] p
);

    logic [OW-1:0] p_ext;

    // Operands are widened to 2W explicitly so the product is exact and the
    // multiply never depends on context-determined width rules.
    generate
        if (SIGNED) begin : g_signed
            logic signed [2*W-1:0] prod;
            assign prod  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            assign p_ext = {{2{prod[2*W-1]}}, prod};
        end else begin : g_unsigned
            logic [2*W-1:0] prod;
            assign prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            assign p_ext = {2'b00, prod};
        end
    endgenerate

    // No reset: contents only matter when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (ce) begin
            p <= p_ext;
        end
    end

endmodule

// File: rtl/complex_mult_pipe.sv
// rtl/complex_mult_pipe.sv - 3-stage pipelined complex multiplier p = a*b with valid/ready flow control
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational from out_ready)
//   ar, ai, br, bi        W-bit operands a = ar + j*ai, b = br + j*bi
//   conj_b                (CMUL_CONJ_EN only) 1: compute a*conj(b) for this beat
//   out_valid / out_ready result handshake
//   pr, pi                OW-bit two's complement result, OW = 2*W+2
//   busy                  any pipeline stage holds a beat
//
// Build option: define CMUL_CONJ_EN to add the conj_b input.
//
// Stages: S1 operand regs, S2 four products (cmul_mult_unit), S3 add/sub into pr/pi.

module complex_mult_pipe
    import cmul_pkg::*;
#(
    parameter int      W      = 32,
    parameter bit      SIGNED = 1'b1,
    localparam int     OW     = cmul_ow(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  ar,
    input  logic [W-1:0]  ai,
    input  logic [W-1:0]  br,
    input  logic [W-1:0]  bi,
`ifdef CMUL_CONJ_EN
    input  logic          conj_b,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] pr,
    output logic [OW-1:0] pi,
    output logic          busy
);

    logic v1, v2, v3;
    logic ready1, ready2, ready3;
    logic ld1, ld2, ld3;

    logic [W-1:0]  ar_q, ai_q, br_q, bi_q;
    logic [OW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic          c2;

    // A stage can take new data when it is empty or its contents move on
    // this cycle; chaining these from the output back collapses bubbles
    // even while the output is stalled.
    assign ready3 = !v3 || out_ready;
    assign ready2 = !v2 || ready3;
    assign ready1 = !v1 || ready2;

    // Data registers only load when a real beat arrives, so bubbles do not
    // toggle them.
    assign ld1 = ready1 && in_valid;
    assign ld2 = ready2 && v1;
    assign ld3 = ready3 && v2;

    assign in_ready  = ready1 && !rst;
    assign out_valid = v3 && !rst;
    assign busy      = (v1 || v2 || v3) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ready1) v1 <= in_valid;
            if (ready2) v2 <= v1;
            if (ready3) v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (ld1) begin
            ar_q <= ar;
            ai_q <= ai;
            br_q <= br;
            bi_q <= bi;
        end
    end

`ifdef CMUL_CONJ_EN
    // The conjugate flag travels with its beat so mixed streams stay exact.
    logic c1;

    always_ff @(posedge clk) begin
        if (ld1) c1 <= conj_b;
        if (ld2) c2 <= c1;
    end
`else
    assign c2 = 1'b0;
`endif

    cmul_mult_unit #(.W(W), .SIGNED(SIGNED)) u_mul_rr (
        .clk (clk), .ce (ld2), .a (ar_q), .b (br_q), .p (p_rr)
    );
    cmul_mult_unit #(.W(W), .SIGNED(SIGNED)) u_mul_ii (
        .clk (clk), .ce (ld2), .a (ai_q), .b (bi_q), .p (p_ii)
    );
    cmul_mult_unit #(.W(W), .SIGNED(SIGNED)) u_mul_ri (
        .clk (clk), .ce (ld2), .a (ar_q), .b (bi_q), .p (p_ri)
    );
    cmul_mult_unit #(.W(W), .SIGNED(SIGNED)) u_mul_ir (
        .clk (clk), .ce (ld2), .a (ai_q), .b (br_q), .p (p_ir)
    );

    // a*b:       pr = rr - ii, pi = ri + ir
    // a*conj(b): pr = rr + ii, pi = ir - ri
    always_ff @(posedge clk) begin
        if (rst) begin
            pr <= '0;
            pi <= '0;
        end else if (ld3) begin
            pr <= c2 ? (p_rr + p_ii) : (p_rr - p_ii);
            pi <= c2 ? (p_ir - p_ri) : (p_ri + p_ir);
        end
    end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// tb/tb_complex_mult_pipe.sv - scoreboard bench for complex_mult_pipe (signed and unsigned W=8 instances)

module tb_complex_mult_pipe;
    import cmul_pkg::*;

    localparam int W  = 8;
    localparam int OW = cmul_ow(W);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid  [2];
    logic          in_ready  [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic          busy      [2];
    logic [W-1:0]  ar [2], ai [2], br [2], bi [2];
    logic [OW-1:0] pr [2], pi [2];
`ifdef CMUL_CONJ_EN
    logic          conj_b [2];
`endif

    complex_mult_pipe #(.W(W), .SIGNED(1'b1)) dut_s (
        .clk (clk), .rst (rst),
        .in_valid (in_valid[0]), .in_ready (in_ready[0]),
        .ar (ar[0]), .ai (ai[0]), .br (br[0]), .bi (bi[0]),
`ifdef CMUL_CONJ_EN
        .conj_b (conj_b[0]),
`endif
        .out_valid (out_valid[0]), .out_ready (out_ready[0]),
        .pr (pr[0]), .pi (pi[0]), .busy (busy[0])
    );

    complex_mult_pipe #(.W(W), .SIGNED(1'b0)) dut_u (
        .clk (clk), .rst (rst),
        .in_valid (in_valid[1]), .in_ready (in_ready[1]),
        .ar (ar[1]), .ai (ai[1]), .br (br[1]), .bi (bi[1]),
`ifdef CMUL_CONJ_EN
        .conj_b (conj_b[1]),
`endif
        .out_valid (out_valid[1]), .out_ready (out_ready[1]),
        .pr (pr[1]), .pi (pi[1]), .busy (busy[1])
    );

    typedef struct {
        logic [OW-1:0] pr;
        logic [OW-1:0] pi;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int occ [2];
    bit rmode  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    // Independent reference: plain 64-bit integer arithmetic, truncated to OW.
    function automatic logic [OW-1:0] model(input bit sgn, input bit cj, input bit im,
                                            input logic [W-1:0] xar, xai, xbr, xbi);
        longint xr, xi, yr, yi, r;
        xr = sgn ? longint'($signed(xar)) : longint'(xar);
        xi = sgn ? longint'($signed(xai)) : longint'(xai);
        yr = sgn ? longint'($signed(xbr)) : longint'(xbr);
        yi = sgn ? longint'($signed(xbi)) : longint'(xbi);
        if (!im) r = cj ? (xr * yr + xi * yi) : (xr * yr - xi * yi);
        else     r = cj ? (xi * yr - xr * yi) : (xr * yi + xi * yr);
        return r[OW-1:0];
    endfunction

    // Present one beat and hold it until accepted; the expected result is
    // queued at the cycle of the transfer.
    task automatic send(input int d, input logic [W-1:0] a_r, a_i, b_r, b_i, input bit cj,
                        input logic [OW-1:0] epr, epi, input bit lat);
        exp_t e;
        int   n;
        ar[d] = a_r; ai[d] = a_i; br[d] = b_r; bi[d] = b_i;
`ifdef CMUL_CONJ_EN
        conj_b[d] = cj;
`endif
        in_valid[d] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready[d]) begin
                e.pr = epr; e.pi = epi; e.acc = cyc; e.lat = lat;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: dut %0d beat not accepted within 200 cycles", d);
                break;
            end
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic send_m(input int d, input logic [W-1:0] a_r, a_i, b_r, b_i, input bit cj,
                          input bit lat);
        send(d, a_r, a_i, b_r, b_i, cj,
             model(d == 0, cj, 1'b0, a_r, a_i, b_r, b_i),
             model(d == 0, cj, 1'b1, a_r, a_i, b_r, b_i), lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d/%0d results still outstanding", q0.size(), q1.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) occ[d] <= 0;
            else     occ[d] <= occ[d] + int'(in_valid[d] && in_ready[d])
                                      - int'(out_valid[d] && out_ready[d]);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rmode) out_ready[0] = 1'($urandom_range(0, 1));
        end
    end

    for (genvar d = 0; d < 2; d++) begin : g_mon
        logic          held;
        logic [OW-1:0] hpr, hpi;
        exp_t          e;

        always @(negedge clk) begin
            if (rst) begin
                held <= 1'b0;
            end else begin
                chk($sformatf("in_ready_%0d", d), in_ready[d], !(occ[d] == 3 && !out_ready[d]));
                if (held) begin
                    chk($sformatf("stall_valid_%0d", d), out_valid[d], 1'b1);
                    chk($sformatf("stall_pr_%0d", d), pr[d], hpr);
                    chk($sformatf("stall_pi_%0d", d), pi[d], hpi);
                end
                held <= out_valid[d] && !out_ready[d];
                hpr  <= pr[d];
                hpi  <= pi[d];
                if (out_valid[d] && out_ready[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output_%0d: pr=%0d pi=%0d with nothing queued",
                                 d, pr[d], pi[d]);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("pr_%0d", d), pr[d], e.pr);
                        chk($sformatf("pi_%0d", d), pi[d], e.pi);
                        if (e.lat) chk($sformatf("latency_%0d", d), 64'(cyc - e.acc), 64'(CMUL_LAT));
                    end
                end
            end
        end
    end

    initial begin
        cmul_pair_t va, vb;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            ar[d] = '0; ai[d] = '0; br[d] = '0; bi[d] = '0;
`ifdef CMUL_CONJ_EN
            conj_b[d] = 1'b0;
`endif
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_valid_%0d", d), out_valid[d], 1'b0);
            chk($sformatf("rst_busy_%0d", d), busy[d], 1'b0);
            chk($sformatf("rst_in_ready_%0d", d), in_ready[d], 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_rst_in_ready_%0d", d), in_ready[d], 1'b1);
            chk($sformatf("post_rst_pr_%0d", d), pr[d], '0);
            chk($sformatf("post_rst_pi_%0d", d), pi[d], '0);
            chk($sformatf("post_rst_out_valid_%0d", d), out_valid[d], 1'b0);
        end
        @(posedge clk); #1;

        // Signed directed vectors, full rate, latency checked
        send(0, 8'd3, 8'd4, 8'd5, 8'hFE, 1'b0, 18'd23, 18'd14, 1'b1);
        drain();
        send(0, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 18'd0, 18'd32768, 1'b1);
        send(0, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0, 18'd16384, 18'd0, 1'b1);
        drain();

        // Unsigned directed vectors
        send(1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 18'h301FF, 18'd0, 1'b1);
        send(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 18'd0, 18'd130050, 1'b1);
        drain();

        // Output stalled: three beats fill the pipe, the fourth waits
        out_ready[0] = 1'b0;
        fork
            begin
                send_m(0, 8'd7,  8'hF9, 8'd2,  8'd9,  1'b0, 1'b0);
                send_m(0, 8'd1,  8'd2,  8'd3,  8'd4,  1'b0, 1'b0);
                send_m(0, 8'h81, 8'd127, 8'd127, 8'h81, 1'b0, 1'b0);
                send_m(0, 8'd10, 8'd20, 8'hF6, 8'hEC, 1'b0, 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join
        drain();

        // Random back-to-back beats with random output backpressure
        rmode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            va = '0; vb = '0;
            va.re[W-1:0] = W'($urandom); va.im[W-1:0] = W'($urandom);
            vb.re[W-1:0] = W'($urandom); vb.im[W-1:0] = W'($urandom);
            send_m(0, va.re[W-1:0], va.im[W-1:0], vb.re[W-1:0], vb.im[W-1:0], 1'b0, 1'b0);
        end
        drain();
        rmode = 1'b0;
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Reset with two beats in flight discards them
        send(0, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 18'd0, 18'd0, 1'b1);
        send(0, 8'd8, 8'd8, 8'd8, 8'd8, 1'b0, 18'd0, 18'd0, 1'b1);
        rst = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", busy[0], 1'b0);
        repeat (5) @(posedge clk); #1;
        send(0, 8'd2, 8'd1, 8'd1, 8'd3, 1'b0, 18'h3FFFF, 18'd7, 1'b1);
        drain();

`ifdef CMUL_CONJ_EN
        send(0, 8'd3, 8'd4, 8'd5, 8'hFE, 1'b1, 18'd7, 18'd26, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) begin
            send_m(0, 8'(3 + i), 8'(4 - 2 * i), 8'(5 * i), 8'(8'hFE + i), 1'(i % 2), 1'b1);
        end
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
